fetch_queue: RTL and testbench

//   Decoupling buffer between the instruction-fetch stage and decode. Holds up to DEPTH

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fq_ptr.sv | 27 ++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: datapath width, canonical NOP and the {pc, inst} entry.
// Imported by the fetch queue and anything else on the IF/ID boundary.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping queue pointer, modulo DEPTH (power of two); clear wins over increment.
// Latency: registered, 1 cycle. No backpressure; the owner gates i_inc.
module fq_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_inc,
    input  logic                     i_clr,
    output logic [$clog2(DEPTH)-1:0] o_ptr
);

    logic [$clog2(DEPTH)-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Fetch->decode decoupling FIFO; head is a combinational read, 1-cycle push-to-valid.
// in_ready is pure occupancy (no full pass-through); FETCH_QUEUE_BYPASS_EN adds an empty-queue bypass.
module fetch_queue #(
    parameter int                        DEPTH = 4,
    parameter int                        XLEN  = riscv_pkg::XLEN,
    parameter logic [riscv_pkg::XLEN-1:0] NOP  = riscv_pkg::NOP_INST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_wr_ptr;
    logic [PW-1:0]   w_rd_ptr;
    logic            w_not_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_byp;

    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_byp = !w_not_empty && in_valid && !flush;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed entry that decode takes this cycle never touches storage.
    assign w_push = in_valid && in_ready && !flush && !(w_byp && out_ready);
    assign w_pop  = w_not_empty && out_ready && !flush;

    fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (reset),
        .i_inc (w_push),
        .i_clr (flush),
        .o_ptr (w_wr_ptr)
    );

    fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (reset),
        .i_inc (w_pop),
        .i_clr (flush),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= '{pc: in_pc, inst: in_inst};
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = NOP;
        if (w_not_empty) begin
            out_valid = 1'b1;
            out_pc    = r_mem[w_rd_ptr].pc;
            out_inst  = r_mem[w_rd_ptr].inst;
        end else if (w_byp) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_entry_t model_q[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare head/occupancy mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        if (reset) begin
            int          sz;
            bit          byp;
            bit          exp_vld;
            logic [31:0] exp_pc;
            logic [31:0] exp_inst;
            sz  = model_q.size();
            byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (sz == 0) && in_valid && !flush;
`endif
            exp_vld  = (sz != 0) || byp;
            exp_pc   = (sz != 0) ? model_q[0].pc   : (byp ? in_pc   : 32'h0);
            exp_inst = (sz != 0) ? model_q[0].inst : (byp ? in_inst : NOP_INST);
            chk("out_valid", out_valid, exp_vld);
            chk("out_pc",    out_pc,    exp_pc);
            chk("out_inst",  out_inst,  exp_inst);
            chk("count",     count,     sz);
            chk("in_ready",  in_ready,  sz != DEPTH);
            if (flush) begin
                model_q.delete();
            end else if (!(byp && out_ready)) begin
                if (sz != 0 && out_ready) void'(model_q.pop_front());
                if (in_valid && sz < DEPTH) model_q.push_back('{pc: in_pc, inst: in_inst});
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc",    out_pc,    32'h0);
        chk("rst_out_inst",  out_inst,  NOP_INST);
        chk("rst_count",     count,     3'd0);
        chk("rst_in_ready",  in_ready,  1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: three pushes with decode stalled
        for (int i = 0; i < 3; i++) drive(1'b1, 32'(i * 4), 32'hA + 32'(i), 1'b0, 1'b0);
        idle(1);
        chk("t1_count", count, 3'd3);
        chk("t1_head",  out_pc, 32'h0);
        chk("t1_ready", in_ready, 1'b1);

        // 2: fill, attempt a fifth push, then drain in order
        drive(1'b1, 32'h0C, 32'hD, 1'b0, 1'b0);
        chk("t2_full_ready", in_ready, 1'b0);
        drive(1'b1, 32'h10, 32'hE, 1'b0, 1'b0);
        chk("t2_full_count", count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", out_pc, 32'(i * 4));
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("t2_empty_count", count, 3'd0);
        chk("t2_empty_inst",  out_inst, NOP_INST);

        // 3: steady push+pop at occupancy 2, pointers wrap
        drive(1'b1, 32'h100, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 32'h2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h108 + 32'(i * 4), 32'h3 + 32'(i), 1'b1, 1'b0);
        chk("t3_count", count, 3'd2);
        drain();

        // 4: flush with a concurrent push
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h200 + 32'(i * 4), 32'h20, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD0, 32'hBAD, 1'b0, 1'b1);
        chk("t4_count", count, 3'd0);
        chk("t4_valid", out_valid, 1'b0);
        idle(2);

        // 5: asynchronous reset between edges
        drive(1'b1, 32'h300, 32'h30, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 32'h31, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        model_q.delete();
        #1;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_count", count, 3'd0);
        chk("t5_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 6: push into empty queue with decode ready
        in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h44; out_ready = 1'b1; flush = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("t6_valid", out_valid, 1'b1);
        chk("t6_pc",    out_pc,    32'h40);
`else
        chk("t6_valid", out_valid, 1'b0);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("t6_count", count, 3'd0);
`else
        chk("t6_count", count, 3'd1);
        chk("t6_late_pc", out_pc, 32'h40);
`endif
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 32'h1000 + 32'(i * 4), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

endmodule
